// File: rtl/mshr_pkg.sv
// Shared widths and retire-state encoding for the MSHR_2 miss scheduler.
package mshr_pkg;

    localparam int addr_bits     = 20;
    localparam int data_bits     = 90;
    localparam int mshr_tag_bits = 3;
    localparam int cpu_id_bits   = 2;
    localparam int num_cpus      = 1 << cpu_id_bits;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_GET  = 2'd1,
        R_RET  = 2'd2,
        R_DEL  = 2'd3
    } retire_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or above ptr, wrapping around.
module rr_arbiter
    import mshr_pkg::*;
(
    input  logic [num_cpus-1:0]    req,
    input  logic [cpu_id_bits-1:0] ptr,
    input  logic                   enable,
    output logic [num_cpus-1:0]    grant,
    output logic [cpu_id_bits-1:0] grant_idx
);

    logic                   found;
    logic [cpu_id_bits-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < num_cpus; i++) begin
            // Index arithmetic wraps because num_cpus is a power of two.
            idx = ptr + cpu_id_bits'(i);
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mshr_miss_scheduler.sv
// Sequences MSHR_2: arbitrates CPU misses into the add port, drains entries to memory,
// and retires memory responses with a get / CPU return / del sequence.
module mshr_miss_scheduler
    import mshr_pkg::*;
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [num_cpus-1:0]             cpu_req_valid,
    output logic [num_cpus-1:0]             cpu_req_ready,
    input  logic [num_cpus*addr_bits-1:0]   cpu_req_addr,
    input  logic [num_cpus*data_bits-1:0]   cpu_req_data,
    input  logic [num_cpus-1:0]             cpu_req_rw,
    input  logic [num_cpus-1:0]             cpu_req_dirty,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic [addr_bits-1:0]            mem_req_addr,
    output logic [data_bits-1:0]            mem_req_data,
    output logic                            mem_req_rw,
    output logic                            mem_req_dirty,
    output logic [mshr_tag_bits-1:0]        mem_req_tag,
    input  logic                            mem_resp_valid,
    output logic                            mem_resp_ready,
    input  logic [mshr_tag_bits-1:0]        mem_resp_tag,
    input  logic [data_bits-1:0]            mem_resp_data,
    output logic                            cpu_resp_valid,
    input  logic                            cpu_resp_ready,
    output logic [cpu_id_bits-1:0]          cpu_resp_cpu_id,
    output logic [addr_bits-1:0]            cpu_resp_addr,
    output logic [data_bits-1:0]            cpu_resp_data,
    output logic                            cpu_resp_rw,
    output logic                            mshr_enable,
    output logic                            mshr_add,
    output logic [addr_bits-1:0]            mshr_add_addr,
    output logic [data_bits-1:0]            mshr_add_data,
    output logic                            mshr_add_rw,
    output logic                            mshr_add_dirty,
    output logic [cpu_id_bits-1:0]          mshr_add_cpu_id,
    output logic                            mshr_del,
    output logic [mshr_tag_bits-1:0]        mshr_del_tag,
    output logic                            mshr_read_next,
    output logic                            mshr_get,
    output logic [mshr_tag_bits-1:0]        mshr_get_tag,
    input  logic                            mshr_rn_valid,
    input  logic [addr_bits-1:0]            rn_addr,
    input  logic [data_bits-1:0]            rn_data,
    input  logic                            rn_rw,
    input  logic                            rn_dirty,
    input  logic [cpu_id_bits-1:0]          rn_cpu_id,
    input  logic [mshr_tag_bits-1:0]        rn_mshr_id,
    input  logic                            mshr_get_valid,
    input  logic [addr_bits-1:0]            get_addr,
    input  logic [data_bits-1:0]            get_data,
    input  logic                            get_rw,
    input  logic                            get_dirty,
    input  logic [cpu_id_bits-1:0]          get_cpu_id,
    input  logic                            mshr_empty,
    input  logic                            mshr_full
);

    logic                     run;
    logic [num_cpus-1:0]      grant;
    logic [cpu_id_bits-1:0]   grant_idx;
    logic                     any_grant;
    logic [cpu_id_bits-1:0]   rr_ptr_q, rr_ptr_d;
    retire_state_e            state_q, state_d;
    logic [mshr_tag_bits-1:0] tag_q, tag_d;
    logic [data_bits-1:0]     data_q, data_d;
    logic [cpu_id_bits-1:0]   cpu_id_q, cpu_id_d;
    logic [addr_bits-1:0]     addr_q, addr_d;
    logic                     rw_q, rw_d;
    logic                     err_bad_tag_q, err_bad_tag_d;
    logic                     unused_inputs;

    // Held reset forces every handshake output low, not just the registered ones.
    assign run = enable & reset;

    rr_arbiter u_rr_arbiter (
        .req       (cpu_req_valid),
        .ptr       (rr_ptr_q),
        .enable    (run & ~mshr_full),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign any_grant       = |grant;
    assign cpu_req_ready   = grant;
    assign mshr_enable     = enable;
    assign mshr_add        = any_grant;
    assign mshr_add_addr   = cpu_req_addr[int'(grant_idx) * addr_bits +: addr_bits];
    assign mshr_add_data   = cpu_req_data[int'(grant_idx) * data_bits +: data_bits];
    assign mshr_add_rw     = cpu_req_rw[grant_idx];
    assign mshr_add_dirty  = cpu_req_dirty[grant_idx];
    assign mshr_add_cpu_id = grant_idx;
    assign rr_ptr_d        = any_grant ? grant_idx + cpu_id_bits'(1) : rr_ptr_q;

    assign mem_req_valid  = run & mshr_rn_valid & ~mshr_empty;
    assign mem_req_addr   = rn_addr;
    assign mem_req_data   = rn_data;
    assign mem_req_rw     = rn_rw;
    assign mem_req_dirty  = rn_dirty;
    assign mem_req_tag    = rn_mshr_id;
    assign mshr_read_next = mem_req_valid & mem_req_ready;

    assign mshr_get_tag    = tag_q;
    assign mshr_del_tag    = tag_q;
    assign cpu_resp_cpu_id = cpu_id_q;
    assign cpu_resp_addr   = addr_q;
    assign cpu_resp_data   = data_q;
    assign cpu_resp_rw     = rw_q;

    assign unused_inputs = ^{rn_cpu_id, get_data, get_dirty};

    always_comb begin
        state_d        = state_q;
        tag_d          = tag_q;
        data_d         = data_q;
        cpu_id_d       = cpu_id_q;
        addr_d         = addr_q;
        rw_d           = rw_q;
        err_bad_tag_d  = err_bad_tag_q;
        mem_resp_ready = 1'b0;
        mshr_get       = 1'b0;
        mshr_del       = 1'b0;
        cpu_resp_valid = 1'b0;
        unique case (state_q)
            R_IDLE: begin
                mem_resp_ready = run;
                if (run && mem_resp_valid) begin
                    tag_d   = mem_resp_tag;
                    data_d  = mem_resp_data;
                    state_d = R_GET;
                end
            end
            R_GET: begin
                mshr_get = run;
                if (run) begin
                    if (mshr_get_valid) begin
                        cpu_id_d = get_cpu_id;
                        addr_d   = get_addr;
                        rw_d     = get_rw;
                        state_d  = R_RET;
                    end else begin
                        // Response for an entry MSHR_2 does not hold: drop it, never del.
                        err_bad_tag_d = 1'b1;
                        state_d       = R_IDLE;
                    end
                end
            end
            R_RET: begin
                cpu_resp_valid = 1'b1;
                if (run && cpu_resp_ready) state_d = R_DEL;
            end
            R_DEL: begin
                mshr_del = run;
                if (run) state_d = R_IDLE;
            end
            default: state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q      <= '0;
            state_q       <= R_IDLE;
            tag_q         <= '0;
            data_q        <= '0;
            cpu_id_q      <= '0;
            addr_q        <= '0;
            rw_q          <= 1'b0;
            err_bad_tag_q <= 1'b0;
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            state_q       <= state_d;
            tag_q         <= tag_d;
            data_q        <= data_d;
            cpu_id_q      <= cpu_id_d;
            addr_q        <= addr_d;
            rw_q          <= rw_d;
            err_bad_tag_q <= err_bad_tag_d;
        end
    end

endmodule

// File: tb/tb_mshr_miss_scheduler.sv
// Self-checking bench for mshr_miss_scheduler: arbiter vector table, directed MSHR
// sequences against a small MSHR_2 model, and randomized cycles against a reference model.
module tb_mshr_miss_scheduler;
    import mshr_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                          reset, enable;
    logic [num_cpus-1:0]           cpu_req_valid, cpu_req_ready, cpu_req_rw, cpu_req_dirty;
    logic [num_cpus*addr_bits-1:0] cpu_req_addr;
    logic [num_cpus*data_bits-1:0] cpu_req_data;
    logic                          mem_req_valid, mem_req_ready, mem_req_rw, mem_req_dirty;
    logic [addr_bits-1:0]          mem_req_addr;
    logic [data_bits-1:0]          mem_req_data;
    logic [mshr_tag_bits-1:0]      mem_req_tag;
    logic                          mem_resp_valid, mem_resp_ready;
    logic [mshr_tag_bits-1:0]      mem_resp_tag;
    logic [data_bits-1:0]          mem_resp_data;
    logic                          cpu_resp_valid, cpu_resp_ready, cpu_resp_rw;
    logic [cpu_id_bits-1:0]        cpu_resp_cpu_id;
    logic [addr_bits-1:0]          cpu_resp_addr;
    logic [data_bits-1:0]          cpu_resp_data;
    logic                          mshr_enable, mshr_add, mshr_add_rw, mshr_add_dirty;
    logic [addr_bits-1:0]          mshr_add_addr;
    logic [data_bits-1:0]          mshr_add_data;
    logic [cpu_id_bits-1:0]        mshr_add_cpu_id;
    logic                          mshr_del, mshr_read_next, mshr_get;
    logic [mshr_tag_bits-1:0]      mshr_del_tag, mshr_get_tag;
    logic                          mshr_rn_valid, rn_rw, rn_dirty;
    logic [addr_bits-1:0]          rn_addr;
    logic [data_bits-1:0]          rn_data;
    logic [cpu_id_bits-1:0]        rn_cpu_id;
    logic [mshr_tag_bits-1:0]      rn_mshr_id;
    logic                          mshr_get_valid, get_rw, get_dirty, mshr_empty, mshr_full;
    logic [addr_bits-1:0]          get_addr;
    logic [data_bits-1:0]          get_data;
    logic [cpu_id_bits-1:0]        get_cpu_id;

    // Manually driven MSHR_2 side (table and random phases).
    logic                     m_rn_valid, m_rn_rw, m_rn_dirty, m_get_valid, m_get_rw, m_get_dirty;
    logic [addr_bits-1:0]     m_rn_addr, m_get_addr;
    logic [data_bits-1:0]     m_rn_data, m_get_data;
    logic [cpu_id_bits-1:0]   m_rn_cpu_id, m_get_cpu_id;
    logic [mshr_tag_bits-1:0] m_rn_id;
    logic                     m_full, m_empty;

    // Behavioural MSHR_2 (directed phase): 8 slots, allocate lowest free, issue lowest pending.
    logic                     use_model = 1'b0;
    logic                     clr_model = 1'b0;
    logic [7:0]               ent_v = '0;
    logic [7:0]               ent_iss = '0;
    logic [addr_bits-1:0]     ent_addr [8];
    logic [data_bits-1:0]     ent_data [8];
    logic                     ent_rw [8];
    logic                     ent_dirty [8];
    logic [cpu_id_bits-1:0]   ent_cpu [8];
    int                       rn_sel, ent_cnt, free_t;

    int n_err = 0;
    int n_chk = 0;

    mshr_miss_scheduler dut (
        .clk (clk), .reset (reset), .enable (enable),
        .cpu_req_valid (cpu_req_valid), .cpu_req_ready (cpu_req_ready),
        .cpu_req_addr (cpu_req_addr), .cpu_req_data (cpu_req_data),
        .cpu_req_rw (cpu_req_rw), .cpu_req_dirty (cpu_req_dirty),
        .mem_req_valid (mem_req_valid), .mem_req_ready (mem_req_ready),
        .mem_req_addr (mem_req_addr), .mem_req_data (mem_req_data), .mem_req_rw (mem_req_rw),
        .mem_req_dirty (mem_req_dirty), .mem_req_tag (mem_req_tag),
        .mem_resp_valid (mem_resp_valid), .mem_resp_ready (mem_resp_ready),
        .mem_resp_tag (mem_resp_tag), .mem_resp_data (mem_resp_data),
        .cpu_resp_valid (cpu_resp_valid), .cpu_resp_ready (cpu_resp_ready),
        .cpu_resp_cpu_id (cpu_resp_cpu_id), .cpu_resp_addr (cpu_resp_addr),
        .cpu_resp_data (cpu_resp_data), .cpu_resp_rw (cpu_resp_rw),
        .mshr_enable (mshr_enable), .mshr_add (mshr_add), .mshr_add_addr (mshr_add_addr),
        .mshr_add_data (mshr_add_data), .mshr_add_rw (mshr_add_rw),
        .mshr_add_dirty (mshr_add_dirty), .mshr_add_cpu_id (mshr_add_cpu_id),
        .mshr_del (mshr_del), .mshr_del_tag (mshr_del_tag), .mshr_read_next (mshr_read_next),
        .mshr_get (mshr_get), .mshr_get_tag (mshr_get_tag),
        .mshr_rn_valid (mshr_rn_valid), .rn_addr (rn_addr), .rn_data (rn_data), .rn_rw (rn_rw),
        .rn_dirty (rn_dirty), .rn_cpu_id (rn_cpu_id), .rn_mshr_id (rn_mshr_id),
        .mshr_get_valid (mshr_get_valid), .get_addr (get_addr), .get_data (get_data),
        .get_rw (get_rw), .get_dirty (get_dirty), .get_cpu_id (get_cpu_id),
        .mshr_empty (mshr_empty), .mshr_full (mshr_full)
    );

    always_comb begin
        rn_sel  = -1;
        ent_cnt = 0;
        for (int t = 7; t >= 0; t--) begin
            if (ent_v[t]) ent_cnt = ent_cnt + 1;
            if (ent_v[t] && !ent_iss[t]) rn_sel = t;
        end
        if (use_model) begin
            mshr_rn_valid  = (rn_sel >= 0);
            rn_mshr_id     = rn_sel[2:0];
            rn_addr        = ent_addr[rn_sel[2:0]];
            rn_data        = ent_data[rn_sel[2:0]];
            rn_rw          = ent_rw[rn_sel[2:0]];
            rn_dirty       = ent_dirty[rn_sel[2:0]];
            rn_cpu_id      = ent_cpu[rn_sel[2:0]];
            mshr_get_valid = ent_v[mshr_get_tag];
            get_addr       = ent_addr[mshr_get_tag];
            get_data       = ent_data[mshr_get_tag];
            get_rw         = ent_rw[mshr_get_tag];
            get_dirty      = ent_dirty[mshr_get_tag];
            get_cpu_id     = ent_cpu[mshr_get_tag];
            mshr_full      = (ent_cnt == 8);
            mshr_empty     = (ent_cnt == 0);
        end else begin
            mshr_rn_valid  = m_rn_valid;
            rn_mshr_id     = m_rn_id;
            rn_addr        = m_rn_addr;
            rn_data        = m_rn_data;
            rn_rw          = m_rn_rw;
            rn_dirty       = m_rn_dirty;
            rn_cpu_id      = m_rn_cpu_id;
            mshr_get_valid = m_get_valid;
            get_addr       = m_get_addr;
            get_data       = m_get_data;
            get_rw         = m_get_rw;
            get_dirty      = m_get_dirty;
            get_cpu_id     = m_get_cpu_id;
            mshr_full      = m_full;
            mshr_empty     = m_empty;
        end
    end

    always @(posedge clk) begin
        if (clr_model) begin
            ent_v   <= '0;
            ent_iss <= '0;
        end else if (use_model) begin
            if (mshr_read_next) ent_iss[rn_mshr_id] <= 1'b1;
            if (mshr_del) ent_v[mshr_del_tag] <= 1'b0;
            if (mshr_add) begin
                free_t = 0;
                for (int t = 7; t >= 0; t--) if (!ent_v[t]) free_t = t;
                ent_v[free_t]     <= 1'b1;
                ent_iss[free_t]   <= 1'b0;
                ent_addr[free_t]  <= mshr_add_addr;
                ent_data[free_t]  <= mshr_add_data;
                ent_rw[free_t]    <= mshr_add_rw;
                ent_dirty[free_t] <= mshr_add_dirty;
                ent_cpu[free_t]   <= mshr_add_cpu_id;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [data_bits-1:0] rnd_data();
        return data_bits'({$urandom(), $urandom(), $urandom()});
    endfunction

    logic [addr_bits-1:0] s_addr [4];
    logic [data_bits-1:0] s_data [4];

    task automatic set_cpu(input int c, input logic [addr_bits-1:0] a,
                           input logic [data_bits-1:0] d, input logic rw, input logic dirty);
        cpu_req_addr[c*addr_bits +: addr_bits] = a;
        cpu_req_data[c*data_bits +: data_bits] = d;
        cpu_req_rw[c]    = rw;
        cpu_req_dirty[c] = dirty;
        s_addr[c] = a;
        s_data[c] = d;
    endtask

    task automatic idle_inputs;
        cpu_req_valid = '0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_tag = '0;
        mem_resp_data = '0; cpu_resp_ready = 1'b0;
        m_rn_valid = 1'b0; m_rn_rw = 1'b0; m_rn_dirty = 1'b0; m_rn_addr = '0; m_rn_data = '0;
        m_rn_cpu_id = '0; m_rn_id = '0; m_get_valid = 1'b0; m_get_rw = 1'b0; m_get_dirty = 1'b0;
        m_get_addr = '0; m_get_data = '0; m_get_cpu_id = '0; m_full = 1'b0; m_empty = 1'b0;
    endtask

    // Reset held with live requests: every handshake/control output must read 0.
    task automatic do_reset;
        reset = 1'b0; enable = 1'b1;
        idle_inputs();
        cpu_req_valid = 4'hF; mem_resp_valid = 1'b1; mem_req_ready = 1'b1; m_rn_valid = 1'b1;
        tick(); tick();
        #3;
        chk("rst_cpu_req_ready", cpu_req_ready, 0);
        chk("rst_mshr_add", mshr_add, 0);
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_read_next", mshr_read_next, 0);
        chk("rst_mem_resp_ready", mem_resp_ready, 0);
        chk("rst_mshr_get", mshr_get, 0);
        chk("rst_mshr_del", mshr_del, 0);
        chk("rst_cpu_resp_valid", cpu_resp_valid, 0);
        chk("rst_rr_ptr", dut.rr_ptr_q, 0);
        chk("rst_state", dut.state_q, R_IDLE);
        idle_inputs();
        reset = 1'b1;
    endtask

    typedef struct {
        logic       en;
        logic       full;
        logic [3:0] valid;
        logic [3:0] exp_ready;
    } arb_vec_t;

    arb_vec_t vecs [12];

    // Reference-model state for the random phase.
    int                   rr_m, st_m, g;
    logic                 err_m;
    logic [2:0]           sv_tag;
    logic [data_bits-1:0] sv_data;
    logic [1:0]           sv_id;
    logic [addr_bits-1:0] sv_addr;
    logic                 sv_rw;

    initial begin
        cpu_req_addr = '0; cpu_req_data = '0; cpu_req_rw = '0; cpu_req_dirty = '0;
        // rr_ptr starts at 0; each grant moves it past the winner.
        vecs[0]  = '{1'b1, 1'b0, 4'b0001, 4'b0001};
        vecs[1]  = '{1'b1, 1'b0, 4'b1111, 4'b0010};
        vecs[2]  = '{1'b1, 1'b0, 4'b1111, 4'b0100};
        vecs[3]  = '{1'b1, 1'b0, 4'b1111, 4'b1000};
        vecs[4]  = '{1'b1, 1'b0, 4'b1111, 4'b0001};
        vecs[5]  = '{1'b1, 1'b0, 4'b0001, 4'b0001};
        vecs[6]  = '{1'b1, 1'b1, 4'b1111, 4'b0000};
        vecs[7]  = '{1'b0, 1'b0, 4'b1111, 4'b0000};
        vecs[8]  = '{1'b1, 1'b0, 4'b1001, 4'b1000};
        vecs[9]  = '{1'b1, 1'b0, 4'b0110, 4'b0010};
        vecs[10] = '{1'b1, 1'b0, 4'b0000, 4'b0000};
        vecs[11] = '{1'b1, 1'b0, 4'b0011, 4'b0001};

        // Table phase: arbiter order, wrap, full and enable gating.
        do_reset();
        for (int c = 0; c < 4; c++) set_cpu(c, 20'(90 + c), 90'(100 + c), ~c[0], c[1]);
        for (int i = 0; i < 12; i++) begin
            int gid;
            tick();
            if (i == 1) chk("rr_ptr_after_cpu0", dut.rr_ptr_q, 1);
            enable = vecs[i].en; m_full = vecs[i].full; cpu_req_valid = vecs[i].valid;
            #3;
            gid = 0;
            for (int c = 0; c < 4; c++) if (vecs[i].exp_ready[c]) gid = c;
            chk($sformatf("vec%0d_ready", i), cpu_req_ready, vecs[i].exp_ready);
            chk($sformatf("vec%0d_add", i), mshr_add, |vecs[i].exp_ready);
            if (vecs[i].exp_ready != 0) begin
                chk($sformatf("vec%0d_cpu_id", i), mshr_add_cpu_id, gid);
                chk($sformatf("vec%0d_addr", i), mshr_add_addr, 90 + gid);
                chk($sformatf("vec%0d_data", i), mshr_add_data, 100 + gid);
                chk($sformatf("vec%0d_rw", i), mshr_add_rw, (gid % 2 == 0));
            end
        end
        enable = 1'b1;

        // Directed phase against the MSHR_2 model.
        use_model = 1'b1; clr_model = 1'b1;
        do_reset();
        tick();
        clr_model = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            cpu_req_valid = 4'(1 << (k % 4));
            set_cpu(k % 4, 20'(90 + k), 90'(100 + k), k[0], 1'b0);
            #3;
            chk($sformatf("fill%0d_grant", k), cpu_req_ready, 1 << (k % 4));
            chk($sformatf("fill%0d_cpu_id", k), mshr_add_cpu_id, k % 4);
            chk($sformatf("fill%0d_addr", k), mshr_add_addr, 90 + k);
            if (k > 0) chk($sformatf("fill%0d_no_rn", k), {mem_req_valid, mshr_read_next}, 2'b10);
        end
        tick();
        cpu_req_valid = 4'b0001;
        set_cpu(0, 20'd98, 90'd200, 1'b0, 1'b1);
        #3;
        chk("full_no_grant", {cpu_req_ready, mshr_add}, 0);
        for (int j = 0; j < 3; j++) begin
            tick();
            mem_req_ready = 1'b1;
            #3;
            chk($sformatf("issue%0d_tag", j), mem_req_tag, j);
            chk($sformatf("issue%0d_rn", j), mshr_read_next, 1);
            chk($sformatf("issue%0d_addr", j), mem_req_addr, 90 + j);
            chk($sformatf("issue%0d_full_hold", j), cpu_req_ready, 0);
        end
        tick();
        mem_req_ready = 1'b0;
        #3;
        chk("stall_no_rn", {mem_req_valid, mshr_read_next, mem_req_tag}, {2'b10, 3'd3});

        tick();
        mem_resp_valid = 1'b1; mem_resp_tag = 3'd1; mem_resp_data = 90'h55;
        #3;
        chk("resp_ready", mem_resp_ready, 1);
        tick();
        mem_resp_valid = 1'b0;
        #3;
        chk("get_pulse", {mshr_get, mshr_get_tag, cpu_resp_valid, mem_resp_ready}, {1'b1, 3'd1, 2'b00});
        for (int d = 0; d < 3; d++) begin
            tick();
            #3;
            chk($sformatf("ret_hold%0d", d), {cpu_resp_valid, cpu_resp_cpu_id, cpu_resp_rw},
                {1'b1, 2'd1, 1'b1});
            chk($sformatf("ret_addr%0d", d), cpu_resp_addr, 91);
            chk($sformatf("ret_data%0d", d), cpu_resp_data, 90'h55);
            chk($sformatf("ret_quiet%0d", d), {mem_resp_ready, mshr_del}, 0);
        end
        tick();
        cpu_resp_ready = 1'b1;
        #3;
        chk("ret_accept", cpu_resp_valid, 1);
        tick();
        cpu_resp_ready = 1'b0;
        #3;
        chk("del_pulse", {mshr_del, mshr_del_tag, cpu_resp_valid}, {1'b1, 3'd1, 1'b0});
        chk("del_cycle_still_full", cpu_req_ready, 0);
        tick();
        #3;
        chk("freed_slot_grant", cpu_req_ready, 4'b0001);
        chk("freed_slot_addr", mshr_add_addr, 98);
        chk("retire_back_idle", {mem_resp_ready, mshr_del}, 2'b10);
        chk("no_bad_tag", dut.err_bad_tag_q, 0);
        tick();
        cpu_req_valid = '0;

        // Reset while the return is pending: no del afterwards.
        mem_resp_valid = 1'b1; mem_resp_tag = 3'd2; mem_resp_data = 90'h77;
        tick();
        mem_resp_valid = 1'b0;
        tick();
        #3;
        chk("mid_ret_valid", {cpu_resp_valid, cpu_resp_addr}, {1'b1, 20'd92});
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #3;
        chk("mid_rst_state", dut.state_q, R_IDLE);
        chk("mid_rst_outputs", {cpu_resp_valid, mshr_del, mshr_get}, 0);
        tick();
        #3;
        chk("mid_rst_no_del", {mshr_del, cpu_resp_valid}, 0);

        // Empty MSHR: no issue, and a response flags a bad tag without del.
        clr_model = 1'b1;
        tick();
        clr_model = 1'b0;
        #3;
        chk("empty_no_issue", mem_req_valid, 0);
        mem_resp_valid = 1'b1; mem_resp_tag = 3'd5; mem_resp_data = 90'h9;
        tick();
        mem_resp_valid = 1'b0;
        #3;
        chk("bad_get", {mshr_get, mshr_get_tag}, {1'b1, 3'd5});
        tick();
        #3;
        chk("bad_back_idle", {cpu_resp_valid, mshr_del, mem_resp_ready}, 3'b001);
        chk("bad_tag_flag", dut.err_bad_tag_q, 1);

        // Random phase against the reference model.
        use_model = 1'b0;
        do_reset();
        rr_m = 0; st_m = 0; err_m = 1'b0;
        sv_tag = '0; sv_data = '0; sv_id = '0; sv_addr = '0; sv_rw = 1'b0;
        for (int n = 0; n < 600; n++) begin
            tick();
            enable = ($urandom % 10) != 0;
            cpu_req_valid = 4'($urandom);
            for (int c = 0; c < 4; c++) set_cpu(c, 20'($urandom), rnd_data(), 1'($urandom), 1'($urandom));
            m_full = ($urandom % 4) == 0;
            m_rn_valid = 1'($urandom);
            m_empty = !m_rn_valid && 1'($urandom);
            m_rn_id = 3'($urandom); m_rn_addr = 20'($urandom); m_rn_data = rnd_data();
            m_rn_rw = 1'($urandom); m_rn_dirty = 1'($urandom);
            mem_req_ready = 1'($urandom);
            mem_resp_valid = ($urandom % 3) == 0;
            mem_resp_tag = 3'($urandom); mem_resp_data = rnd_data();
            cpu_resp_ready = ($urandom % 3) == 0;
            m_get_valid = ($urandom % 8) != 0;
            m_get_addr = 20'($urandom); m_get_cpu_id = 2'($urandom); m_get_rw = 1'($urandom);
            #3;
            g = -1;
            if (enable && !m_full)
                for (int k = 0; k < 4; k++)
                    if (g < 0 && cpu_req_valid[(rr_m + k) % 4]) g = (rr_m + k) % 4;
            chk("r_ready", cpu_req_ready, (g >= 0) ? (1 << g) : 0);
            if (g >= 0) begin
                chk("r_add_id", mshr_add_cpu_id, g);
                chk("r_add_payload", {mshr_add_addr, mshr_add_data, mshr_add_rw, mshr_add_dirty},
                    {s_addr[g], s_data[g], cpu_req_rw[g], cpu_req_dirty[g]});
            end
            chk("r_issue", {mem_req_valid, mshr_read_next},
                {enable && m_rn_valid && !m_empty, enable && m_rn_valid && !m_empty && mem_req_ready});
            if (mem_req_valid) chk("r_issue_tag", {mem_req_tag, mem_req_addr}, {m_rn_id, m_rn_addr});
            chk("r_resp_ready", mem_resp_ready, enable && st_m == 0);
            chk("r_get", mshr_get, enable && st_m == 1);
            if (st_m == 1) chk("r_get_tag", mshr_get_tag, sv_tag);
            chk("r_cpu_resp_valid", cpu_resp_valid, st_m == 2);
            if (st_m == 2)
                chk("r_cpu_resp", {cpu_resp_cpu_id, cpu_resp_addr, cpu_resp_data, cpu_resp_rw},
                    {sv_id, sv_addr, sv_data, sv_rw});
            chk("r_del", mshr_del, enable && st_m == 3);
            if (st_m == 3) chk("r_del_tag", mshr_del_tag, sv_tag);
            if (enable) begin
                if (g >= 0) rr_m = (g + 1) % 4;
                case (st_m)
                    0: if (mem_resp_valid) begin
                        st_m = 1; sv_tag = mem_resp_tag; sv_data = mem_resp_data;
                    end
                    1: if (m_get_valid) begin
                        st_m = 2; sv_id = m_get_cpu_id; sv_addr = m_get_addr; sv_rw = m_get_rw;
                    end else begin
                        st_m = 0; err_m = 1'b1;
                    end
                    2: if (cpu_resp_ready) st_m = 3;
                    default: st_m = 0;
                endcase
            end
        end
        tick();
        chk("r_err_sticky", dut.err_bad_tag_q, err_m);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mshr_miss_scheduler.md
Name: mshr_miss_scheduler

Overview:
- Controller that sequences the MSHR_2 miss buffer between four CPU-side miss requesters and one memory port.
- Round-robin arbitrates CPU misses into the MSHR add port.
- Drains pending entries to memory through read_next.
- Retires memory responses with a get → CPU return → del sequence.
- Sits between the cache miss logic and the memory interface, owning every MSHR_2 control pin.

Parameters:
- addr_bits, 20, address width.
- data_bits, 90, data/payload width.
- mshr_tag_bits, 3, MSHR entry tag width (8 entries).
- cpu_id_bits, 2, requester id width.
- num_cpus, 4, number of requesters (= 2**cpu_id_bits).

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  global enable; also drives mshr_enable.
- cpu_req_valid / cpu_req_ready  in/out  num_cpus each  per-CPU miss handshake; ready is a one-hot grant.
- cpu_req_addr / cpu_req_data  in  num_cpus*addr_bits / num_cpus*data_bits  packed per-CPU payload, CPU i at slice i.
- cpu_req_rw / cpu_req_dirty  in  num_cpus each  per-CPU request attributes.
- mem_req_valid / mem_req_ready  out/in  1 each  memory issue handshake.
- mem_req_addr / mem_req_data / mem_req_rw / mem_req_dirty / mem_req_tag  out  addr_bits/data_bits/1/1/mshr_tag_bits  issued entry.
- mem_resp_valid / mem_resp_ready  in/out  1 each  memory response handshake.
- mem_resp_tag / mem_resp_data  in  mshr_tag_bits / data_bits  response tag and fill data.
- cpu_resp_valid / cpu_resp_ready  out/in  1 each  return handshake to the owning CPU.
- cpu_resp_cpu_id / cpu_resp_addr / cpu_resp_data / cpu_resp_rw  out  cpu_id_bits/addr_bits/data_bits/1  return payload.
- mshr_enable / mshr_add / mshr_add_addr / mshr_add_data / mshr_add_rw / mshr_add_dirty / mshr_add_cpu_id  out  MSHR_2 add side.
- mshr_del / mshr_del_tag / mshr_read_next / mshr_get / mshr_get_tag  out  MSHR_2 control side.
- mshr_rn_valid / rn_addr / rn_data / rn_rw / rn_dirty / rn_cpu_id / rn_mshr_id  in  MSHR_2 read-next outputs.
- mshr_get_valid / get_addr / get_data / get_rw / get_dirty / get_cpu_id, mshr_empty, mshr_full  in  MSHR_2 lookup outputs and status.

Behaviour:
- Reset (reset==0 at an edge):
  - rr_ptr=0, FSM=R_IDLE, all latches cleared.
  - All handshake and MSHR control outputs read 0 in the cycle after the reset edge.
  - Reset mid-sequence abandons any response in flight with no del.
- enable==0:
  - No grant, no issue, mem_resp_ready=0.
  - FSM holds its state; cpu_resp_valid holds its value.
- Add arbiter (combinational, same cycle):
  - If enable && !mshr_full, grant the first valid CPU scanning from rr_ptr upward, with wrap.
  - cpu_req_ready[g]=1, mshr_add=1, add_* = CPU g slice, add_cpu_id=g.
  - On grant, rr_ptr <= g+1 mod num_cpus; otherwise rr_ptr holds.
  - mshr_full gates the grant even if a del retires in the same cycle; the freed slot is usable the next cycle.
- Issue path (combinational pass-through):
  - mem_req_valid = enable && mshr_rn_valid; mem_req_* = rn_*; mem_req_tag = rn_mshr_id.
  - mshr_read_next = mem_req_valid && mem_req_ready.
  - One entry is issued per accepted cycle.
- Retire FSM, states R_IDLE, R_GET, R_RET, R_DEL:
  - R_IDLE: mem_resp_ready=1 (when enabled). On mem_resp_valid, latch tag and data, go to R_GET.
  - R_GET (1 cycle): mshr_get=1, get_tag=latched tag.
    - Latch get_cpu_id, get_addr, get_rw at the edge, go to R_RET.
    - If mshr_get_valid==0, raise sticky err_bad_tag (internal, visible to the bench) and go to R_IDLE without del.
  - R_RET: cpu_resp_valid=1 with latched cpu_id/addr/rw and mem data. Hold until cpu_resp_ready, then go to R_DEL.
  - R_DEL (1 cycle): mshr_del=1, del_tag=latched tag, go to R_IDLE.
  - Minimum retire latency: 4 cycles from response acceptance to the next mem_resp_ready.
- Concurrency:
  - Add, issue and retire are independent and may all fire in the same cycle.
  - MSHR_2 must accept simultaneous add+del+read_next.
- Empty: with mshr_empty, mem_req_valid=0. A response still follows the FSM and flags err_bad_tag.

Decomposition:
- Shared package mshr_pkg:
  - width constants addr_bits, data_bits, mshr_tag_bits, cpu_id_bits, num_cpus;
  - retire-state encoding (R_IDLE=0, R_GET=1, R_RET=2, R_DEL=3).
- One sub-module rr_arbiter:
  - inputs: request vector, pointer, enable;
  - outputs: one-hot grant and encoded index.
- The top level holds the pointer, the retire FSM and the MSHR wiring.

Test Plan:
- Reset then CPU0 miss addr=90 data=100 rw=1 → cpu_req_ready[0] and mshr_add the same cycle, add_cpu_id=0; rr_ptr becomes 1.
- CPUs 0–3 all valid for 4 cycles → grants in order 0,1,2,3 (one-hot), then back to 0.
- 8 adds addr=90..97 → mshr_full; a 9th request addr=98 stays ungranted until a del, then is granted the cycle after the del.
- mem_req_ready=1 with entries pending → mem_req_tag 0,1,2 on consecutive cycles with mshr_read_next pulsed each cycle; mem_req_ready=0 → no read_next.
- mem_resp tag=1 data=0x55 → get_tag=1 after 1 cycle; cpu_resp_cpu_id=1 addr=91 data=0x55; cpu_resp_ready delayed 3 cycles → valid held; del_tag=1 the cycle after acceptance.
- reset=0 asserted in R_RET → FSM back to R_IDLE, cpu_resp_valid=0, no mshr_del issued.
